// File: rtl/vec_issue_ctrl.sv
// vec_issue_ctrl
//
// Issue controller between the scalar pipeline's vector decode stage and
// vec_exec. Incoming vector instructions are queued in a small circular
// FIFO. One instruction at a time is dispatched to vec_exec with a
// single-cycle new_instr pulse. The operands are held stable until
// vec_op_done, and the result is returned on a valid/ready writeback
// channel. Instructions with a reserved vsew encoding (4..7) never reach
// vec_exec. They return an error writeback with zero data instead.
//
// Ports:
//   clk, reset                 clock (rising edge), async active-high reset
//   req_valid / req_ready      request handshake from the pipeline
//   req_vsew, req_funct6,      instruction fields and source operands
//   req_vd, req_opa, req_opb
//   new_instr                  one-cycle start pulse to vec_exec
//   vsew, funct6,              dispatch registers, stable from ISSUE to WAIT
//   operand_a, operand_b
//   vec_exec_out, vec_op_done  result and completion strobe from vec_exec
//   wb_valid / wb_ready        writeback handshake
//   wb_vd, wb_data, wb_err     writeback tag, data and reserved-vsew flag
//   busy                       FSM not idle or FIFO not empty
//   op_count                   saturating count of completed writebacks
module vec_issue_ctrl #(
  parameter int VLEN   = 256,
  parameter int QDEPTH = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_vsew,
  input  logic [5:0]       req_funct6,
  input  logic [4:0]       req_vd,
  input  logic [VLEN-1:0]  req_opa,
  input  logic [VLEN-1:0]  req_opb,
  output logic             new_instr,
  output logic [2:0]       vsew,
  output logic [5:0]       funct6,
  output logic [VLEN-1:0]  operand_a,
  output logic [VLEN-1:0]  operand_b,
  input  logic [VLEN-1:0]  vec_exec_out,
  input  logic             vec_op_done,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [4:0]       wb_vd,
  output logic [VLEN-1:0]  wb_data,
  output logic             wb_err,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  localparam int PTR_W   = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int QCNT_W  = $clog2(QDEPTH + 1);
  localparam int ENTRY_W = 3 + 6 + 5 + 2 * VLEN;
  localparam logic [QCNT_W-1:0] QFULL = QCNT_W'(QDEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    WB    = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ENTRY_W-1:0]  fifo_q [QDEPTH];
  logic [ENTRY_W-1:0]  fifo_d [QDEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [QCNT_W-1:0]   count_q, count_d;
  logic [2:0]          vsew_q, vsew_d;
  logic [5:0]          funct6_q, funct6_d;
  logic [VLEN-1:0]     opa_q, opa_d;
  logic [VLEN-1:0]     opb_q, opb_d;
  logic [4:0]          vd_q, vd_d;
  logic [VLEN-1:0]     wb_data_q, wb_data_d;
  logic                wb_err_q, wb_err_d;
  logic [CNT_W-1:0]    op_count_q, op_count_d;

  logic                empty, full, push, pop;
  logic [ENTRY_W-1:0]  head;
  logic [2:0]          head_vsew;
  logic [5:0]          head_funct6;
  logic [4:0]          head_vd;
  logic [VLEN-1:0]     head_opa, head_opb;

  // req_ready depends only on the registered count, never on req_valid.
  assign empty = (count_q == '0);
  assign full  = (count_q == QFULL);
  assign push  = req_valid && !full;

  assign head        = fifo_q[rd_ptr_q];
  assign head_vsew   = head[ENTRY_W-1  -: 3];
  assign head_funct6 = head[ENTRY_W-4  -: 6];
  assign head_vd     = head[ENTRY_W-10 -: 5];
  assign head_opa    = head[2*VLEN-1   -: VLEN];
  assign head_opb    = head[VLEN-1:0];

  // Dispatch FSM. A pop happens from IDLE, or from WB on the writeback
  // handshake so that queued work follows with no IDLE bubble. Reserved
  // heads (vsew[2] set) skip vec_exec and go straight to an error writeback
  // without disturbing the operands currently on the dispatch outputs.
  always_comb begin
    state_d    = state_q;
    vsew_d     = vsew_q;
    funct6_d   = funct6_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    vd_d       = vd_q;
    wb_data_d  = wb_data_q;
    wb_err_d   = wb_err_q;
    op_count_d = op_count_q;
    pop        = 1'b0;

    case (state_q)
      IDLE: begin
        if (!empty) pop = 1'b1;
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (vec_op_done) begin
          wb_data_d = vec_exec_out;
          wb_err_d  = 1'b0;
          state_d   = WB;
        end
      end
      WB: begin
        if (wb_ready) begin
          if (op_count_q != '1) op_count_d = op_count_q + CNT_W'(1);
          if (!empty) pop = 1'b1;
          else        state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (pop) begin
      vd_d = head_vd;
      if (head_vsew[2]) begin
        wb_err_d  = 1'b1;
        wb_data_d = '0;
        state_d   = WB;
      end else begin
        vsew_d   = head_vsew;
        funct6_d = head_funct6;
        opa_d    = head_opa;
        opb_d    = head_opb;
        wb_err_d = 1'b0;
        state_d  = ISSUE;
      end
    end
  end

  // Circular FIFO bookkeeping. Push and pop never target the same slot:
  // push needs a free slot and pop needs a filled one.
  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      fifo_d[wr_ptr_q] = {req_vsew, req_funct6, req_vd, req_opa, req_opb};
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + QCNT_W'(1);
      2'b01:   count_d = count_q - QCNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State register. Reset flushes the queue and abandons any in-flight op.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      for (int i = 0; i < QDEPTH; i++) fifo_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      vsew_q     <= '0;
      funct6_q   <= '0;
      opa_q      <= '0;
      opb_q      <= '0;
      vd_q       <= '0;
      wb_data_q  <= '0;
      wb_err_q   <= 1'b0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      vsew_q     <= vsew_d;
      funct6_q   <= funct6_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      vd_q       <= vd_d;
      wb_data_q  <= wb_data_d;
      wb_err_q   <= wb_err_d;
      op_count_q <= op_count_d;
    end
  end

  assign req_ready = !full;
  assign new_instr = (state_q == ISSUE);
  assign wb_valid  = (state_q == WB);
  assign busy      = (state_q != IDLE) || !empty;
  assign vsew      = vsew_q;
  assign funct6    = funct6_q;
  assign operand_a = opa_q;
  assign operand_b = opb_q;
  assign wb_vd     = vd_q;
  assign wb_data   = wb_data_q;
  assign wb_err    = wb_err_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_vec_issue_ctrl.sv
// tb_vec_issue_ctrl
//
// Testbench for vec_issue_ctrl. A behavioural vec_exec model returns
// operand_a + operand_b a programmable number of cycles after new_instr.
// Expected writebacks are built from the requests themselves: reserved
// vsew gives an error with zero data, otherwise the sum of the operands.
// These expectations are kept in a queue in issue order.
module tb_vec_issue_ctrl;

  localparam int VLEN    = 256;
  localparam int QDEPTH  = 2;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [2:0]       req_vsew = '0;
  logic [5:0]       req_funct6 = '0;
  logic [4:0]       req_vd = '0;
  logic [VLEN-1:0]  req_opa = '0;
  logic [VLEN-1:0]  req_opb = '0;
  logic             new_instr;
  logic [2:0]       vsew;
  logic [5:0]       funct6;
  logic [VLEN-1:0]  operand_a, operand_b;
  logic [VLEN-1:0]  vec_exec_out = '0;
  logic             vec_op_done = 1'b0;
  logic             wb_valid;
  logic             wb_ready = 1'b0;
  logic [4:0]       wb_vd;
  logic [VLEN-1:0]  wb_data;
  logic             wb_err;
  logic             busy;
  logic [CNT_W-1:0] op_count;

  typedef struct {
    logic [4:0]      vd;
    logic            err;
    logic [VLEN-1:0] data;
  } wb_exp_t;

  wb_exp_t exp_q[$];
  int n_done = 0;
  int n_tests = 0;
  int n_fail = 0;

  int              done_delay = 4;
  bit              inject_issue = 1'b0;
  int              stale_req = 0;
  int              stale_seen = 0;
  int              done_cnt = 0;
  logic [VLEN-1:0] pend_res = '0;

  vec_issue_ctrl #(.VLEN(VLEN), .QDEPTH(QDEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_vsew(req_vsew), .req_funct6(req_funct6), .req_vd(req_vd),
    .req_opa(req_opa), .req_opb(req_opb),
    .new_instr(new_instr), .vsew(vsew), .funct6(funct6),
    .operand_a(operand_a), .operand_b(operand_b),
    .vec_exec_out(vec_exec_out), .vec_op_done(vec_op_done),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_vd(wb_vd), .wb_data(wb_data), .wb_err(wb_err),
    .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // vec_exec model: latch the sum on new_instr, strobe done done_delay
  // cycles later. It can also fire a spurious done in the ISSUE cycle, or
  // a stale done on request.
  always @(negedge clk) begin
    vec_op_done = 1'b0;
    if (reset) begin
      done_cnt = 0;
    end else begin
      if (done_cnt > 0) begin
        done_cnt = done_cnt - 1;
        if (done_cnt == 0) begin
          vec_op_done  = 1'b1;
          vec_exec_out = pend_res;
        end
      end
      if (new_instr) begin
        pend_res = operand_a + operand_b;
        done_cnt = done_delay;
        if (inject_issue) begin
          vec_op_done  = 1'b1;
          vec_exec_out = '1;
        end
      end
      if (stale_req != stale_seen) begin
        stale_seen   = stale_seen + 1;
        vec_op_done  = 1'b1;
        vec_exec_out = '1;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [VLEN-1:0] rand_vec();
    logic [VLEN-1:0] v;
    for (int i = 0; i < VLEN / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [CNT_W-1:0] exp_cnt();
    return (n_done > CNT_MAX) ? CNT_W'(CNT_MAX) : CNT_W'(n_done);
  endfunction

  // Offer one request and wait (bounded) until it is taken. Returns at the
  // falling edge right after the accepting rising edge.
  task automatic push_op(input logic [2:0] s, input logic [5:0] f, input logic [4:0] d,
                         input logic [VLEN-1:0] a, input logic [VLEN-1:0] b, output bit ok);
    int waited = 0;
    wb_exp_t e;
    req_vsew = s; req_funct6 = f; req_vd = d; req_opa = a; req_opb = b;
    req_valid = 1'b1;
    while (!req_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    ok = req_ready;
    @(negedge clk);
    req_valid = 1'b0;
    if (ok) begin
      e.vd   = d;
      e.err  = (s > 3'd3);
      e.data = e.err ? '0 : (a + b);
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_wb(output bit seen, output int cycles);
    cycles = 0;
    while (!wb_valid && cycles < 200) begin
      @(negedge clk);
      cycles++;
    end
    seen = wb_valid;
  endtask

  task automatic handshake();
    wb_ready = 1'b1;
    @(negedge clk);
    wb_ready = 1'b0;
    n_done++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({new_instr, wb_valid, wb_err, busy, op_count, vsew, funct6, wb_vd} !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_ctrl: got ni=%b wv=%b err=%b busy=%b cnt=%0d vsew=%0d f6=%0d vd=%0d, want all 0",
               new_instr, wb_valid, wb_err, busy, op_count, vsew, funct6, wb_vd);
    end
    n_tests++;
    if ({operand_a, operand_b, wb_data} !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_data: operands/wb_data not zero, wb_data=%h", wb_data);
    end
    n_tests++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL reset_req_ready: got %b want 1", req_ready);
    end
    reset = 1'b0;
    n_done = 0;
    exp_q.delete();
    @(negedge clk);
  endtask

  task automatic test_single_op();
    bit ok, seen;
    int cyc;
    wb_exp_t e;
    done_delay = 4;
    push_op(3'd2, 6'h00, 5'd3, {32{8'h01}}, {32{8'h02}}, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("[TB] FAIL single_push: got not accepted want accepted"); end
    n_tests++;
    if (new_instr !== 1'b0) begin n_fail++; $display("[TB] FAIL single_ni_T1: got %b want 0", new_instr); end
    @(negedge clk);
    n_tests++;
    if (new_instr !== 1'b1) begin n_fail++; $display("[TB] FAIL single_ni_T2: got %b want 1", new_instr); end
    @(negedge clk);
    n_tests++;
    if (new_instr !== 1'b0) begin n_fail++; $display("[TB] FAIL single_ni_width: got %b want 0", new_instr); end
    wait_wb(seen, cyc);
    n_tests++;
    if (!seen || cyc != 4) begin
      n_fail++;
      $display("[TB] FAIL single_wb_latency: got seen=%b after %0d cycles want seen=1 after 4", seen, cyc);
    end
    e = exp_q.pop_front();
    n_tests++;
    if ({wb_vd, wb_err, wb_data} !== {5'd3, 1'b0, {32{8'h03}}} || e.data !== {32{8'h03}}) begin
      n_fail++;
      $display("[TB] FAIL single_wb: got vd=%0d err=%b data=%h want vd=3 err=0 data=03..03", wb_vd, wb_err, wb_data);
    end
    handshake();
    n_tests++;
    if (op_count !== exp_cnt() || op_count !== 2'd1) begin
      n_fail++;
      $display("[TB] FAIL single_count: got %0d want 1", op_count);
    end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL single_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_fill_backpressure();
    bit ok, seen;
    int cyc;
    wb_exp_t e;
    done_delay = 3;
    wb_ready = 1'b0;
    push_op(3'($urandom_range(0, 3)), 6'($urandom), 5'd1, rand_vec(), rand_vec(), ok);
    wait_wb(seen, cyc);
    n_tests++;
    if (!seen) begin n_fail++; $display("[TB] FAIL fill_first_wb: got no wb_valid want wb_valid"); end
    push_op(3'($urandom_range(0, 3)), 6'($urandom), 5'd2, rand_vec(), rand_vec(), ok);
    push_op(3'($urandom_range(0, 3)), 6'($urandom), 5'd3, rand_vec(), rand_vec(), ok);
    n_tests++;
    if (!ok || exp_q.size() != 3) begin
      n_fail++;
      $display("[TB] FAIL fill_pushes: got %0d queued want 3", exp_q.size());
    end
    n_tests++;
    if (req_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL fill_req_ready: got %b want 0", req_ready); end
    req_vsew = 3'd0; req_vd = 5'd4; req_opa = rand_vec(); req_opb = rand_vec();
    req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (req_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL fill_stall%0d: req_ready got %b want 0", i, req_ready); end
      @(negedge clk);
    end
    req_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wait_wb(seen, cyc);
      e = exp_q.pop_front();
      n_tests++;
      if (!seen || {wb_vd, wb_err, wb_data} !== {e.vd, e.err, e.data} || wb_vd !== 5'(k + 1)) begin
        n_fail++;
        $display("[TB] FAIL fill_wb%0d: got v=%b vd=%0d err=%b data=%h want vd=%0d err=%b data=%h",
                 k, seen, wb_vd, wb_err, wb_data, e.vd, e.err, e.data);
      end
      handshake();
      n_tests++;
      if (op_count !== exp_cnt()) begin n_fail++; $display("[TB] FAIL fill_count%0d: got %0d want %0d", k, op_count, exp_cnt()); end
      if (k < 2) begin
        n_tests++;
        if (new_instr !== 1'b1) begin n_fail++; $display("[TB] FAIL fill_no_bubble%0d: new_instr got %b want 1", k, new_instr); end
      end
    end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL fill_drained_busy: got %b want 0", busy); end
  endtask

  task automatic test_reserved();
    bit ok;
    bit saw_pulse = 1'b0;
    int n = 0;
    wb_exp_t e;
    push_op(3'd5, 6'($urandom), 5'd7, rand_vec(), rand_vec(), ok);
    while (!wb_valid && n < 20) begin
      saw_pulse |= new_instr;
      @(negedge clk);
      n++;
    end
    saw_pulse |= new_instr;
    n_tests++;
    if (saw_pulse || !wb_valid) begin
      n_fail++;
      $display("[TB] FAIL reserved_dispatch: got new_instr_seen=%b wb_valid=%b want 0 and 1", saw_pulse, wb_valid);
    end
    e = exp_q.pop_front();
    n_tests++;
    if ({wb_vd, wb_err, wb_data} !== {e.vd, e.err, e.data} || wb_err !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL reserved_wb: got vd=%0d err=%b data=%h want vd=7 err=1 data=0", wb_vd, wb_err, wb_data);
    end
    handshake();
    n_tests++;
    if (op_count !== exp_cnt()) begin n_fail++; $display("[TB] FAIL reserved_count: got %0d want %0d", op_count, exp_cnt()); end
  endtask

  task automatic test_operand_stability();
    bit ok, seen;
    int cyc;
    wb_exp_t e;
    logic [2:0] s;
    logic [5:0] f;
    logic [VLEN-1:0] a, b;
    s = 3'($urandom_range(0, 3)); f = 6'($urandom); a = rand_vec(); b = rand_vec();
    done_delay = 10;
    inject_issue = 1'b1;
    push_op(s, f, 5'($urandom), a, b, ok);
    @(negedge clk);
    n_tests++;
    if (new_instr !== 1'b1) begin n_fail++; $display("[TB] FAIL stab_issue: new_instr got %b want 1", new_instr); end
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      n_tests++;
      if ({operand_a, operand_b, vsew, funct6} !== {a, b, s, f}) begin
        n_fail++;
        $display("[TB] FAIL stab_hold%0d: got vsew=%0d f6=%h a=%h want vsew=%0d f6=%h a=%h",
                 i, vsew, funct6, operand_a, s, f, a);
      end
      n_tests++;
      if (wb_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL stab_early_wb%0d: got %b want 0", i, wb_valid); end
    end
    inject_issue = 1'b0;
    wait_wb(seen, cyc);
    e = exp_q.pop_front();
    n_tests++;
    if (!seen || cyc != 1 || {wb_vd, wb_err, wb_data} !== {e.vd, e.err, e.data}) begin
      n_fail++;
      $display("[TB] FAIL stab_wb: got v=%b cyc=%0d vd=%0d err=%b data=%h want cyc=1 vd=%0d err=%b data=%h",
               seen, cyc, wb_vd, wb_err, wb_data, e.vd, e.err, e.data);
    end
    handshake();
  endtask

  task automatic test_random();
    bit ok, seen;
    int cyc, hold;
    wb_exp_t e;
    for (int p = 0; p < 8; p++) begin
      done_delay = $urandom_range(1, 5);
      for (int j = 0; j < 2; j++)
        push_op(3'($urandom_range(0, 7)), 6'($urandom), 5'($urandom), rand_vec(), rand_vec(), ok);
      for (int j = 0; j < 2; j++) begin
        wait_wb(seen, cyc);
        e = exp_q.pop_front();
        n_tests++;
        if (!seen || {wb_vd, wb_err, wb_data} !== {e.vd, e.err, e.data}) begin
          n_fail++;
          $display("[TB] FAIL rand_wb%0d_%0d: got v=%b vd=%0d err=%b data=%h want vd=%0d err=%b data=%h",
                   p, j, seen, wb_vd, wb_err, wb_data, e.vd, e.err, e.data);
        end
        hold = $urandom_range(0, 3);
        repeat (hold) @(negedge clk);
        n_tests++;
        if (!wb_valid || {wb_vd, wb_err, wb_data} !== {e.vd, e.err, e.data}) begin
          n_fail++;
          $display("[TB] FAIL rand_held%0d_%0d: got v=%b vd=%0d data=%h want vd=%0d data=%h",
                   p, j, wb_valid, wb_vd, wb_data, e.vd, e.data);
        end
        handshake();
        n_tests++;
        if (op_count !== exp_cnt()) begin n_fail++; $display("[TB] FAIL rand_count%0d_%0d: got %0d want %0d", p, j, op_count, exp_cnt()); end
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    bit ok;
    done_delay = 50;
    push_op(3'd1, 6'($urandom), 5'd9, rand_vec(), rand_vec(), ok);
    repeat (2) @(negedge clk);
    push_op(3'd0, 6'($urandom), 5'd10, rand_vec(), rand_vec(), ok);
    n_tests++;
    if (busy !== 1'b1 || req_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL midwait_setup: got busy=%b req_ready=%b want 1 1", busy, req_ready);
    end
    #2;
    reset = 1'b1;
    #1;
    n_tests++;
    if ({new_instr, wb_valid, wb_err, busy, op_count, vsew, funct6, wb_vd} !== '0) begin
      n_fail++;
      $display("[TB] FAIL midwait_ctrl: got ni=%b wv=%b err=%b busy=%b cnt=%0d vsew=%0d f6=%0d vd=%0d, want all 0",
               new_instr, wb_valid, wb_err, busy, op_count, vsew, funct6, wb_vd);
    end
    n_tests++;
    if ({operand_a, operand_b, wb_data} !== '0) begin
      n_fail++;
      $display("[TB] FAIL midwait_data: operands/wb_data not zero, operand_a=%h", operand_a);
    end
    n_tests++;
    if (req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL midwait_req_ready: got %b want 1", req_ready); end
    exp_q.delete();
    n_done = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    stale_req++;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_tests++;
      if (wb_valid !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL midwait_stale%0d: got wb_valid=%b busy=%b want 0 0", i, wb_valid, busy);
      end
    end
  endtask

  task automatic test_saturation();
    bit ok, seen;
    int cyc;
    wb_exp_t e;
    for (int i = 0; i < 5; i++) begin
      done_delay = $urandom_range(1, 4);
      push_op(3'($urandom_range(0, 7)), 6'($urandom), 5'($urandom), rand_vec(), rand_vec(), ok);
      wait_wb(seen, cyc);
      e = exp_q.pop_front();
      n_tests++;
      if (!seen || {wb_vd, wb_err, wb_data} !== {e.vd, e.err, e.data}) begin
        n_fail++;
        $display("[TB] FAIL sat_wb%0d: got v=%b vd=%0d err=%b want vd=%0d err=%b", i, seen, wb_vd, wb_err, e.vd, e.err);
      end
      handshake();
      n_tests++;
      if (op_count !== exp_cnt()) begin n_fail++; $display("[TB] FAIL sat_count%0d: got %0d want %0d", i, op_count, exp_cnt()); end
    end
    n_tests++;
    if (op_count !== 2'd3) begin n_fail++; $display("[TB] FAIL sat_stuck: got %0d want 3", op_count); end
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_fill_backpressure();
    test_reserved();
    test_operand_stability();
    test_random();
    test_reset_mid_wait();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
